// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth multiplier.
// Holds the FSM state encoding, the 3-bit Booth window codes and the
// operand extension width helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth window {b[2i+1], b[2i], b[2i-1]} codes and the digit each selects.
    localparam logic [2:0] WIN_ZERO_LO = 3'b000;  //  0
    localparam logic [2:0] WIN_POS1_A  = 3'b001;  // +1
    localparam logic [2:0] WIN_POS1_B  = 3'b010;  // +1
    localparam logic [2:0] WIN_POS2    = 3'b011;  // +2
    localparam logic [2:0] WIN_NEG2    = 3'b100;  // -2
    localparam logic [2:0] WIN_NEG1_A  = 3'b101;  // -1
    localparam logic [2:0] WIN_NEG1_B  = 3'b110;  // -1
    localparam logic [2:0] WIN_ZERO_HI = 3'b111;  //  0

    // One guard bit above N keeps unsigned operands positive after
    // extension; rounding up to even gives a whole number of digits.
    function automatic int ext_width(input int n);
        return (n + 1) + ((n + 1) % 2);
    endfunction

endpackage

// File: rtl/booth_r4_digit_enc.sv
// Radix-4 Booth digit encoder: 3-bit window -> {neg, one, two} select.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the window.
// Ports: window (in, 3) | neg (out) digit negative | one (out) |digit|=1 | two (out) |digit|=2
module booth_r4_digit_enc
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output logic       neg,
    output logic       one,
    output logic       two
);

    always_comb begin
        neg = 1'b0;
        one = 1'b0;
        two = 1'b0;
        case (window)
            WIN_POS1_A, WIN_POS1_B: one = 1'b1;
            WIN_POS2:               two = 1'b1;
            WIN_NEG2: begin
                neg = 1'b1;
                two = 1'b1;
            end
            WIN_NEG1_A, WIN_NEG1_B: begin
                neg = 1'b1;
                one = 1'b1;
            end
            default: ;  // WIN_ZERO_LO / WIN_ZERO_HI: digit 0
        endcase
    end

endmodule

// File: rtl/booth_r4_mult_seq.sv
// Sequential radix-4 Booth multiplier, N-bit operands, per-transaction signed/unsigned.
// Latency: out_valid D = ext_width(N)/2 edges after accept (1..D with BOOTH_EARLY_TERM_EN).
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE (no overlap).
// Ports: clk, rst_n (async, active-low) | in_valid/in_ready, a, b, is_signed |
//        out_valid/out_ready, result (2N).
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as the remaining multiplier digits are all 0.
module booth_r4_mult_seq
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] result
);

    localparam int W     = ext_width(N);
    localparam int D     = W / 2;
    localparam int CNT_W = $clog2(D);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

    state_t           state, state_nxt;
    logic [2*W-1:0]   mcand;     // ext(a) pre-shifted by 2i for the current digit
    logic [W:0]       mplier;    // {ext(b),0} shifted right 2 per digit; window in [2:0]
    logic [2*W-1:0]   acc;
    logic [2*W-1:0]   addend;
    logic [2*W-1:0]   acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2*N-1:0]   result_q;
    logic [2*W-1:0]   a_ext;
    logic [W-1:0]     b_ext;
    logic             dig_neg, dig_one, dig_two;
    logic             last_digit;

    // The mode only matters at capture: it is folded into the extension,
    // so no separate mode register is kept.
    assign a_ext = {{(2*W-N){is_signed & a[N-1]}}, a};
    assign b_ext = {{(W-N){is_signed & b[N-1]}}, b};

    booth_r4_digit_enc u_enc (
        .window (mplier[2:0]),
        .neg    (dig_neg),
        .one    (dig_one),
        .two    (dig_two)
    );

    always_comb begin
        addend = '0;
        if (dig_two) begin
            addend = mcand << 1;
        end else if (dig_one) begin
            addend = mcand;
        end
        acc_nxt = dig_neg ? (acc - addend) : (acc + addend);
    end

`ifdef BOOTH_EARLY_TERM_EN
    // Bits above the just-used window all equal: every later window is
    // 000 or 111, i.e. digit 0. Shifted-in sign copies do not disturb this.
    logic rest_same;
    assign rest_same  = (&mplier[W:2]) | ~(|mplier[W:2]);
    assign last_digit = (cnt == CNT_LAST) || rest_same;
`else
    assign last_digit = (cnt == CNT_LAST);
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = CALC;
            CALC:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                mcand  <= a_ext;
                mplier <= {b_ext, 1'b0};
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 2;
                mplier <= {{2{mplier[W]}}, mplier[W:2]};
                cnt    <= cnt + CNT_W'(1);
                if (last_digit) begin
                    result_q <= acc_nxt[2*N-1:0];
                end
            end
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_booth_r4_mult_seq.sv
module tb_booth_r4_mult_seq;

    localparam int D = 5;
`ifdef BOOTH_EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a_i = '0;
    logic [7:0]  b_i = '0;
    logic        sgn_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;

    int checks = 0;
    int failures = 0;

    booth_r4_mult_seq #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .is_signed (sgn_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic [15:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called #1 after an accept edge; returns edges until out_valid seen.
    task automatic wait_out(output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (lat >= 20) begin
                checks++;
                failures++;
                $display("FAIL timeout waiting for out_valid actual=0 required=1");
                break;
            end
        end
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                          output logic [15:0] res, output int lat);
        a_i      = ta;
        b_i      = tb;
        sgn_i    = ts;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out(lat);
        res = result;
    endtask

    // Completes the output handshake (out_ready assumed high).
    task automatic finish_op();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [15:0] res;
        logic [15:0] expv;
        logic [7:0]  ra, rb;
        logic        rs;
        logic        saw_valid;
        int          lat;

        vt[0] = '{8'h80, 8'h80, 1'b1, 16'h4000, ET ? 4 : D};
        vt[1] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01, D};
        vt[2] = '{8'hFF, 8'hFF, 1'b1, 16'h0001, ET ? 1 : D};
        vt[3] = '{8'hFD, 8'h05, 1'b1, 16'hFFF1, ET ? 2 : D};
        vt[4] = '{8'h05, 8'hFD, 1'b1, 16'hFFF1, ET ? 2 : D};
        vt[5] = '{8'h7F, 8'h01, 1'b1, 16'h007F, ET ? 1 : D};
        vt[6] = '{8'h7F, 8'hFF, 1'b1, 16'hFF81, ET ? 1 : D};
        vt[7] = '{8'h03, 8'h40, 1'b1, 16'h00C0, ET ? 4 : D};
        vt[8] = '{8'h00, 8'h00, 1'b0, 16'h0000, ET ? 1 : D};

        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {16'd0, result}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            run_op(vt[i].a, vt[i].b, vt[i].sgn, res, lat);
            check($sformatf("vec%0d_result", i), {16'd0, res}, {16'd0, vt[i].exp});
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
            finish_op();
            check($sformatf("vec%0d_idle_after_hs", i), {30'd0, out_valid, in_ready}, 32'b01);
        end

        // Backpressure: result held, new operands ignored until handshake
        out_ready = 1'b0;
        run_op(8'h12, 8'h34, 1'b0, res, lat);
        check("bp_result", {16'd0, res}, 32'h03A8);
        a_i      = 8'h55;
        b_i      = 8'h02;
        sgn_i    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp_hold%0d", k), {14'd0, out_valid, in_ready, result}, {14'd0, 2'b10, 16'h03A8});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_idle", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_new_accepted", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("bp_new_latency", lat, ET ? 2 : D);
        check("bp_new_result", {16'd0, result}, 32'h00AA);
        finish_op();

        // Asynchronous reset during the third CALC cycle
        a_i      = 8'h11;
        b_i      = 8'h11;
        sgn_i    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_calc_busy", {30'd0, out_valid, in_ready}, 32'b00);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_regs", {14'd0, in_ready, out_valid, result}, {14'd0, 2'b10, 16'h0000});
        @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        check("no_spurious_out_valid", {31'd0, saw_valid}, 32'd0);
        check("post_rst_result", {16'd0, result}, 32'd0);

        // Random vectors against an arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            if (rs) expv = 16'($signed({{8{ra[7]}}, ra}) * $signed({{8{rb[7]}}, rb}));
            else    expv = 16'({8'd0, ra} * {8'd0, rb});
            run_op(ra, rb, rs, res, lat);
            check($sformatf("rand%0d_result a=%0h b=%0h s=%0d", n, ra, rb, rs), {16'd0, res}, {16'd0, expv});
            if (ET) check($sformatf("rand%0d_latency_range", n), {31'd0, (lat >= 1 && lat <= D)}, 32'd1);
            else    check($sformatf("rand%0d_latency", n), lat, D);
            finish_op();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
